// File: rtl/cpu_pkg.sv
// Shared 6502 status-register definitions: P bit positions, flag instruction
// and branch condition encodings.
package cpu_pkg;

  localparam int FLAG_N = 7;
  localparam int FLAG_V = 6;
  localparam int FLAG_B = 4;
  localparam int FLAG_D = 3;
  localparam int FLAG_I = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [2:0] {
    FOP_NONE = 3'd0,
    FOP_SEC  = 3'd1,
    FOP_CLC  = 3'd2,
    FOP_SEI  = 3'd3,
    FOP_CLI  = 3'd4,
    FOP_SED  = 3'd5,
    FOP_CLD  = 3'd6,
    FOP_CLV  = 3'd7
  } flag_op_t;

  typedef enum logic [2:0] {
    BR_BPL = 3'd0,
    BR_BMI = 3'd1,
    BR_BVC = 3'd2,
    BR_BVS = 3'd3,
    BR_BCC = 3'd4,
    BR_BCS = 3'd5,
    BR_BNE = 3'd6,
    BR_BEQ = 3'd7
  } br_sel_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous active-low lines; resets to the
// inactive (high) level so nothing looks asserted coming out of reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/status_reg.sv
// 6502 processor status register: flag capture/set/clear/load, PHP image,
// branch condition select, and synchronised IRQ/NMI request generation.
module status_reg
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_zero,
  input  logic       alu_negative,
  input  logic       alu_overflow,
  input  logic       alu_c_out,
  input  logic [3:0] upd_mask,
  input  logic [2:0] flag_op,
  input  logic       p_load,
  input  logic [7:0] p_in,
  input  logic       set_i,
  input  logic       push_brk,
  output logic [7:0] p_out,
  output logic       c_flag,
  output logic       d_flag,
  output logic       i_flag,
  input  logic [2:0] br_sel,
  output logic       br_taken,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       nmi_ack,
  output logic       irq_pending,
  output logic       nmi_pending
);

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic irq_sync, nmi_sync;
  logic nmi_dly_q, nmi_latch_q, nmi_latch_d;
  logic nmi_edge;
  flag_op_t fop;
  logic unused_p_in;

  assign fop         = flag_op_t'(flag_op);
  assign unused_p_in = ^p_in[5:4];

  // Priority per flag: p_load, then set_i (I only), then flag_op, then ALU capture.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (p_load) begin
      n_d = p_in[FLAG_N];
      v_d = p_in[FLAG_V];
      d_d = p_in[FLAG_D];
      i_d = p_in[FLAG_I];
      z_d = p_in[FLAG_Z];
      c_d = p_in[FLAG_C];
    end else begin
      if (upd_mask[3]) n_d = alu_negative;

      if (fop == FOP_CLV)   v_d = 1'b0;
      else if (upd_mask[2]) v_d = alu_overflow;

      if (fop == FOP_SED)      d_d = 1'b1;
      else if (fop == FOP_CLD) d_d = 1'b0;

      if (set_i || fop == FOP_SEI) i_d = 1'b1;
      else if (fop == FOP_CLI)     i_d = 1'b0;

      if (upd_mask[1]) z_d = alu_zero;

      if (fop == FOP_SEC)      c_d = 1'b1;
      else if (fop == FOP_CLC) c_d = 1'b0;
      else if (upd_mask[0])    c_d = alu_c_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 1'b0;
      v_q <= 1'b0;
      d_q <= 1'b0;
      i_q <= 1'b1;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  always_comb begin
    p_out         = 8'h20;
    p_out[FLAG_N] = n_q;
    p_out[FLAG_V] = v_q;
    p_out[FLAG_B] = push_brk;
    p_out[FLAG_D] = d_q;
    p_out[FLAG_I] = i_q;
    p_out[FLAG_Z] = z_q;
    p_out[FLAG_C] = c_q;
  end

  assign c_flag = c_q;
  assign d_flag = d_q;
  assign i_flag = i_q;

  always_comb begin
    br_taken = 1'b0;
    case (br_sel_t'(br_sel))
      BR_BPL: br_taken = ~n_q;
      BR_BMI: br_taken = n_q;
      BR_BVC: br_taken = ~v_q;
      BR_BVS: br_taken = v_q;
      BR_BCC: br_taken = ~c_q;
      BR_BCS: br_taken = c_q;
      BR_BNE: br_taken = ~z_q;
      BR_BEQ: br_taken = z_q;
      default: br_taken = 1'b0;
    endcase
  end

  sync2 u_irq_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (irq_n),
    .q_o  (irq_sync)
  );

  sync2 u_nmi_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (nmi_n),
    .q_o  (nmi_sync)
  );

  assign irq_pending = ~irq_sync & ~i_q;

  // A new edge beats a same-cycle ack so a back-to-back NMI is never lost.
  assign nmi_edge = nmi_dly_q & ~nmi_sync;

  always_comb begin
    nmi_latch_d = nmi_latch_q;
    if (nmi_edge)     nmi_latch_d = 1'b1;
    else if (nmi_ack) nmi_latch_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_dly_q   <= 1'b1;
      nmi_latch_q <= 1'b0;
    end else begin
      nmi_dly_q   <= nmi_sync;
      nmi_latch_q <= nmi_latch_d;
    end
  end

  assign nmi_pending = nmi_latch_q;

endmodule
